exe_unit_arbiter: RTL

Controller that shares one `exe_unit_w1` execution unit between two requesters. It arbitrates requests round-robin and captures the winner's operation and operands. It drives them steadily into the execution unit for a parameterised latency, then returns the captured result and status to the granted requester with a one-cycle done pulse. It sits between the two issuing blocks and the execution unit instance; the unit itself is unchanged.

---
 rtl/exe_unit_arbiter_if.sv | 23 ++
 rtl/exe_unit_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/exe_unit_arbiter_if.sv
// exe_unit_arbiter_if: requester and execution-unit signals of the arbiter
// Requester side: i_req*, i_oper*, i_argA*, i_argB* in; o_ack*, o_done*, o_result, o_status, o_busy out
// Unit side: o_eu_oper, o_eu_argA, o_eu_argB out; i_eu_result, i_eu_status in
interface exe_unit_arbiter_if #(parameter int m = 4, parameter int n = 2);
    logic         i_req0, i_req1;
    logic [n-1:0] i_oper0, i_oper1;
    logic [m-1:0] i_argA0, i_argB0, i_argA1, i_argB1;
    logic         o_ack0, o_ack1, o_done0, o_done1, o_busy;
    logic [m-1:0] o_result;
    logic [3:0]   o_status;
    logic [n-1:0] o_eu_oper;
    logic [m-1:0] o_eu_argA, o_eu_argB;
    logic [m-1:0] i_eu_result;
    logic [3:0]   i_eu_status;
    modport slave (
        input  i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argB0, i_argA1, i_argB1, i_eu_result, i_eu_status,
        output o_ack0, o_ack1, o_done0, o_done1, o_busy, o_result, o_status, o_eu_oper, o_eu_argA, o_eu_argB
    );
    modport master (
        output i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argB0, i_argA1, i_argB1, i_eu_result, i_eu_status,
        input  o_ack0, o_ack1, o_done0, o_done1, o_busy, o_result, o_status, o_eu_oper, o_eu_argA, o_eu_argB
    );
endinterface

// File: rtl/exe_unit_arbiter.sv
// exe_unit_arbiter: round-robin sharing of one execution unit between two requesters
// Ports: i_clk clock, i_rsn sync active-high reset, bus (slave) requester and unit signals
module exe_unit_arbiter #(
    parameter int m   = 4,
    parameter int n   = 2,
    parameter int LAT = 1
) (
    input logic i_clk,
    input logic i_rsn,
    exe_unit_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t       r_state, w_next;
    logic         r_g, r_last, r_ack0, r_ack1, r_done0, r_done1, r_busy;
    logic [2:0]   r_cnt;
    logic [m-1:0] r_result, r_eu_argA, r_eu_argB;
    logic [3:0]   r_status;
    logic [n-1:0] r_eu_oper;
    logic         w_grant, w_win, w_done;
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win   = 1'b0;
        w_done  = 1'b0;
        if (r_state == IDLE) begin
            w_grant = bus.i_req0 | bus.i_req1;
            // on contention the requester not served last wins
            w_win   = (bus.i_req0 & bus.i_req1) ? ~r_last : bus.i_req1;
            w_next  = w_grant ? BUSY : IDLE;
        end else begin
            w_done = r_cnt == 3'd0;
            w_next = w_done ? IDLE : BUSY;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_g       <= 1'b0;
            r_last    <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_busy    <= 1'b0;
            r_result  <= '0;
            r_status  <= '0;
            r_eu_oper <= '0;
            r_eu_argA <= '0;
            r_eu_argB <= '0;
        end else begin
            r_state <= w_next;
            r_ack0  <= w_grant & ~w_win;
            r_ack1  <= w_grant & w_win;
            r_done0 <= w_done & ~r_g;
            r_done1 <= w_done & r_g;
            if (w_grant) begin
                r_g       <= w_win;
                r_last    <= w_win;
                r_cnt     <= 3'(LAT);
                r_busy    <= 1'b1;
                r_eu_oper <= w_win ? bus.i_oper1 : bus.i_oper0;
                r_eu_argA <= w_win ? bus.i_argA1 : bus.i_argA0;
                r_eu_argB <= w_win ? bus.i_argB1 : bus.i_argB0;
            end else if (r_state == BUSY && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_done) begin
                r_result <= bus.i_eu_result;
                r_status <= bus.i_eu_status;
                r_busy   <= 1'b0;
            end
        end
    end
    assign bus.o_ack0    = r_ack0;
    assign bus.o_ack1    = r_ack1;
    assign bus.o_done0   = r_done0;
    assign bus.o_done1   = r_done1;
    assign bus.o_busy    = r_busy;
    assign bus.o_result  = r_result;
    assign bus.o_status  = r_status;
    assign bus.o_eu_oper = r_eu_oper;
    assign bus.o_eu_argA = r_eu_argA;
    assign bus.o_eu_argB = r_eu_argB;
endmodule
